// File: rtl/phase_fp_encoder.sv
// phase_fp_encoder: signed fixed-point ADC phase sample -> IEEE-754 single.
// Three registered stages (abs, normalize, round/pack) with valid/ready
// handshake and full backpressure. Result value is i_data * 2^-FRAC_W.
// Optional build macro PHASE_FP_RNE_EN selects round-to-nearest-even;
// without it the dropped low bits are truncated toward zero.
module phase_fp_encoder #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [31:0]       o_phase,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  localparam int MAG_W   = DATA_W + 1;
  localparam int SHIFT_W = $clog2(MAG_W + 1);
  localparam int EXP_W   = 10;

  logic stall;

  logic              s1_valid;
  logic              s1_sign;
  logic              s1_zero;
  logic [MAG_W-1:0]  s1_mag;

  logic              s2_valid;
  logic              s2_sign;
  logic              s2_zero;
  logic [MAG_W-1:0]  s2_mant;
  logic [EXP_W-1:0]  s2_exp;

  logic [MAG_W-1:0]  data_ext;
  logic [MAG_W-1:0]  abs_mag;

  logic [SHIFT_W-1:0] msb_idx;
  logic [MAG_W-1:0]   norm_mant;
  logic [EXP_W-1:0]   norm_exp;

  logic [DATA_W+23:0] low_ext;
  logic [22:0]        frac_trunc;
  logic [22:0]        frac_rnd;
  logic               round_up;
  logic               carry;
  logic [EXP_W-1:0]   exp_rnd;

  // Whole pipeline freezes only when the output word is waiting on downstream.
  assign stall   = o_valid && !i_ready;
  assign o_ready = !stall;
  assign o_busy  = s1_valid | s2_valid | o_valid;

  // Stage 1 combinational: magnitude in one extra bit so the most negative input is exact.
  always_comb begin
    data_ext = {i_data[DATA_W-1], i_data};
    abs_mag  = i_data[DATA_W-1] ? (~data_ext + MAG_W'(1)) : data_ext;
  end

  // Stage 1 register: sign, zero flag and magnitude.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_mag   <= '0;
    end else if (!stall) begin
      s1_valid <= i_valid;
      s1_sign  <= i_data[DATA_W-1];
      s1_zero  <= (i_data == '0);
      s1_mag   <= abs_mag;
    end
  end

  // Stage 2 combinational: priority-encode the leading one and left-justify it to bit DATA_W.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (s1_mag[i]) msb_idx = SHIFT_W'(i);
    end
    norm_mant = s1_mag << (SHIFT_W'(DATA_W) - msb_idx);
    norm_exp  = EXP_W'(127) + EXP_W'(msb_idx) - EXP_W'(FRAC_W);
  end

  // Stage 2 register: normalized mantissa and biased exponent.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_mant  <= '0;
      s2_exp   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_mant  <= norm_mant;
      s2_exp   <= norm_exp;
    end
  end

  // Stage 3 combinational: split fraction/guard/sticky, apply rounding, fold carry into the exponent.
  // Padding with 24 zeros keeps the slicing valid for narrow DATA_W, where nothing is ever dropped.
  always_comb begin
    low_ext    = {s2_mant[DATA_W-1:0], 24'b0};
    frac_trunc = low_ext[DATA_W+23 -: 23];
`ifdef PHASE_FP_RNE_EN
    round_up   = low_ext[DATA_W] & ((|low_ext[DATA_W-1:0]) | frac_trunc[0]);
`else
    round_up   = 1'b0;
`endif
    {carry, frac_rnd} = {1'b0, frac_trunc} + 24'(round_up);
    exp_rnd    = carry ? (s2_exp + EXP_W'(1)) : s2_exp;
  end

  // Hidden bit and upper exponent bits are implied by construction; truncation also ignores guard/sticky.
  logic unused_bits;
`ifdef PHASE_FP_RNE_EN
  assign unused_bits = ^{s2_mant[DATA_W], exp_rnd[EXP_W-1:8]};
`else
  assign unused_bits = ^{s2_mant[DATA_W], exp_rnd[EXP_W-1:8], low_ext[DATA_W:0], carry};
`endif

  // Stage 3 register: packed single-precision word; zero is always +0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_phase <= 32'h0;
    end else if (!stall) begin
      o_valid <= s2_valid;
      o_phase <= s2_zero ? 32'h0 : {s2_sign, exp_rnd[7:0], frac_rnd};
    end
  end

endmodule

// File: tb/tb_phase_fp_encoder.sv
// Self-checking bench for phase_fp_encoder: directed vectors, backpressure,
// mid-stream reset and a randomized stream against an integer-arithmetic
// float reference model.
module tb_phase_fp_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_phase;
  logic        o_ready4, o_valid4, o_busy4;
  logic [31:0] o_phase4;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] src_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_phase = 32'h0;

  always #5 clk = ~clk;

  phase_fp_encoder #(.DATA_W(32), .FRAC_W(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(o_ready),
    .o_phase(o_phase), .o_valid(o_valid), .i_ready(ready), .o_busy(o_busy)
  );

  phase_fp_encoder #(.DATA_W(32), .FRAC_W(4)) dut_f4 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(o_ready4),
    .o_phase(o_phase4), .o_valid(o_valid4), .i_ready(ready), .o_busy(o_busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: exact integer magnitude, leading-one search, then keep 24 significant bits.
  function automatic logic [31:0] fp_model(input logic [31:0] d, input int frac_w);
    longint x, a, q;
    int     e;
    logic   s;
    x = longint'($signed(d));
    s = (x < 0);
    a = s ? -x : x;
    if (a == 0) return 32'h0;
    e = 0;
    while ((a >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = a << (23 - e);
    end else begin
      q = a >> (e - 23);
`ifdef PHASE_FP_RNE_EN
      begin
        longint rem, half;
        rem  = a - (q << (e - 23));
        half = longint'(1) << (e - 24);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (longint'(1) << 24)) begin
          q = q >> 1;
          e++;
        end
      end
`endif
    end
    return {s, 8'(127 + e - frac_w), q[22:0]};
  endfunction

  task automatic drive(input int p_valid, input int p_ready);
    valid = (src_q.size() > 0) && ($urandom_range(99) < p_valid);
    data  = (src_q.size() > 0) ? src_q[0] : $urandom;
    ready = ($urandom_range(99) < p_ready);
  endtask

  // One clock with scoreboard bookkeeping; samples mid-cycle.
  task automatic step(input bit chk_stall_ready);
    #4;
    if (chk_stall_ready) check("stall_o_ready", 32'(o_ready), 32'd0);
    if (prev_stall) begin
      check("stall_hold_valid", 32'(o_valid), 32'd1);
      check("stall_hold_phase", o_phase, prev_phase);
    end
    if (o_valid && ready) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("out_phase", o_phase, exp_q.pop_front());
    end
    if (valid && o_ready && !rst) begin
      exp_q.push_back(fp_model(data, 0));
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    prev_stall = o_valid && !ready;
    prev_phase = o_phase;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      drive(100, 100);
      step(1'b0);
      n++;
    end
    check("drain_src_empty", 32'(src_q.size()), 32'd0);
    check("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    valid = 1'b0;
    step(1'b0);
    check("drain_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic run_one(input logic [31:0] d, output logic [31:0] r, output logic [31:0] r4);
    valid = 1'b1;
    data  = d;
    ready = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    for (int k = 0; k < 10 && !o_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("one_valid", 32'(o_valid), 32'd1);
    check("one_valid_f4", 32'(o_valid4), 32'd1);
    r  = o_phase;
    r4 = o_phase4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, r4;
    logic [31:0] dir_in [7];
    logic [31:0] dir_exp[7];
    int n;

    rst = 1'b1; valid = 1'b0; ready = 1'b1; data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_busy",  32'(o_busy),  32'd0);
    check("rst_o_phase", o_phase,      32'h0);
    check("rst_o_ready", 32'(o_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back pair with exact 3-cycle latency.
    for (int c = 0; c < 6; c++) begin
      valid = (c < 2);
      data  = (c == 0) ? 32'd310 : 32'd100;
      #4;
      check("lat_o_valid", 32'(o_valid), 32'((c == 3) || (c == 4)));
      if (c == 3) check("lat_310", o_phase, 32'h439B0000);
      if (c == 4) check("lat_100", o_phase, 32'h42C80000);
      @(posedge clk);
      #1;
    end

    dir_in[0] = 32'hFFFF_FF9C;  dir_exp[0] = 32'hC2C80000;
    dir_in[1] = 32'h0;          dir_exp[1] = 32'h00000000;
    dir_in[2] = 32'h8000_0000;  dir_exp[2] = 32'hCF000000;
    dir_in[3] = 32'd1;          dir_exp[3] = 32'h3F800000;
    dir_in[4] = 32'hFFFF_FFFF;  dir_exp[4] = 32'hBF800000;
`ifdef PHASE_FP_RNE_EN
    dir_in[5] = 32'd16777219;   dir_exp[5] = 32'h4B800002;
    dir_in[6] = 32'h7FFF_FFFF;  dir_exp[6] = 32'h4F000000;
`else
    dir_in[5] = 32'd16777219;   dir_exp[5] = 32'h4B800001;
    dir_in[6] = 32'h7FFF_FFFF;  dir_exp[6] = 32'h4EFFFFFF;
`endif
    for (int i = 0; i < 7; i++) begin
      run_one(dir_in[i], r, r4);
      check($sformatf("dir_%0d", i), r, dir_exp[i]);
    end

    run_one(32'd1600, r, r4);
    check("frac4_1600", r4, 32'h42C80000);
    run_one(32'hFFFF_FF9C, r, r4);
    check("frac4_m100", r4, 32'hC0C80000);

    // Backpressure: 4 samples, hold downstream off for 5 cycles once output appears.
    src_q = '{32'd5, 32'hFFFF_FFF9, 32'd123456789, 32'h0010_0000};
    ready = 1'b1;
    n = 0;
    while (!o_valid && n < 10) begin
      valid = (src_q.size() > 0);
      data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
      step(1'b0);
      n++;
    end
    check("bp_valid_rise", 32'(o_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      ready = 1'b0;
      valid = (src_q.size() > 0);
      data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
      step(1'b1);
    end
    drain(50);

    // Reset with three samples in flight.
    src_q = '{32'd11, 32'd22, 32'd33};
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1;
      data  = src_q[0];
      step(1'b0);
    end
    rst = 1'b1; valid = 1'b0;
    step(1'b0);
    check("midrst_o_valid", 32'(o_valid), 32'd0);
    check("midrst_o_busy",  32'(o_busy),  32'd0);
    exp_q.delete(); src_q.delete(); prev_stall = 1'b0;
    rst = 1'b0;
    valid = 1'b1; data = 32'd777;
    @(posedge clk);
    #1;
    valid = 1'b0;
    n = 1;
    while (!o_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("postrst_latency", 32'(n), 32'd3);
    check("postrst_phase", o_phase, fp_model(32'd777, 0));
    @(posedge clk);
    #1;

    // Randomized stream with random valid/ready.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] v;
      case ($urandom_range(3))
        0: v = $urandom;
        1: v = 32'($urandom_range(2000)) - 32'd1000;
        2: v = (32'd1 << $urandom_range(30, 24)) | ($urandom & 32'h00FF_FFFF);
        default: begin
          case ($urandom_range(3))
            0: v = 32'h0;
            1: v = 32'h8000_0000;
            2: v = 32'h7FFF_FFFF;
            default: v = 32'hFFFF_FFFF;
          endcase
        end
      endcase
      if ($urandom_range(1) == 1) v = -v;
      src_q.push_back(v);
    end
    n = 0;
    while (src_q.size() > 0 && n < 60000) begin
      drive(75, 75);
      step(1'b0);
      n++;
    end
    drain(100);
    check("final_busy_f4", 32'(o_busy4), 32'd0);
    check("final_ready_f4", 32'(o_ready4), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
